// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared memory port: instruction fetch (IF) vs load/store (LS).
// LS wins contested cycles until its streak reaches MAX_LS_STREAK; a watchdog aborts hung accesses.
module mem_port_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_LS_STREAK = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_be,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            sel,
  output logic            err
);

  localparam int BW = DW / 8;
  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            sel_q, sel_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]   mem_be_q, mem_be_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            ls_rvalid_q, ls_rvalid_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   ls_rdata_q, ls_rdata_d;
  logic            err_q, err_d;
  logic            if_win_s, ls_win_s;

  // Arbitration: only meaningful in IDLE; the streak cap hands a contested cycle to IF.
  always_comb begin
    if_win_s = 1'b0;
    ls_win_s = 1'b0;
    if (state_q == S_IDLE) begin
      if (if_req && ls_req) begin
        if (streak_q == STREAK_MAX) begin
          if_win_s = 1'b1;
        end else begin
          ls_win_s = 1'b1;
        end
      end else begin
        if_win_s = if_req;
        ls_win_s = ls_req;
      end
    end else begin
      if_win_s = 1'b0;
      ls_win_s = 1'b0;
    end
  end

  // Next-state, latched access fields, watchdog and completion generation.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    wd_d        = wd_q;
    sel_d       = sel_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ls_win_s) begin
          state_d     = S_BUSY;
          mem_req_d   = 1'b1;
          wd_d        = '0;
          sel_d       = 1'b1;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          mem_be_d    = ls_be;
          if (if_req) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
        end else if (if_win_s) begin
          state_d     = S_BUSY;
          mem_req_d   = 1'b1;
          wd_d        = '0;
          sel_d       = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = {BW{1'b1}};
          streak_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (mem_ack || (wd_q == WD_LAST)) begin
          // A timed-out access completes with zero data and the error flag.
          state_d     = S_DONE;
          mem_req_d   = 1'b0;
          err_d       = ~mem_ack;
          if_rvalid_d = ~sel_q;
          ls_rvalid_d = sel_q;
          if (sel_q) begin
            ls_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            if_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      streak_q    <= '0;
      wd_q        <= '0;
      sel_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      wd_q        <= wd_d;
      sel_q       <= sel_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      err_q       <= err_d;
    end
  end

  assign if_gnt    = if_win_s;
  assign ls_gnt    = ls_win_s;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign sel       = sel_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and checks them against if/ls rvalid.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_we, mem_ack;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  ls_be;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, sel, err;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .sel(sel), .err(err)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion must match the oldest scoreboard entry, including its cycle.
  always @(negedge clk) begin
    if (if_rvalid || ls_rvalid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rvalid: got if=%b ls=%b expected none (cycle %0d)",
                 if_rvalid, ls_rvalid, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check1("rvalid_owner", ls_rvalid, mon_e.is_ls);
        check1("rvalid_both", if_rvalid & ls_rvalid, 1'b0);
        check32("rdata", mon_e.is_ls ? ls_rdata : if_rdata, mon_e.data);
        check1("err", err, mon_e.err);
        check32("rvalid_cycle", cyc, mon_e.cyc);
      end
    end else if (err) begin
      n_vec++;
      n_err++;
      $display("FAIL err_without_rvalid: got 1 expected 0 (cycle %0d)", cyc);
    end
  end

  // One access: request at cycle T, ack k cycles after mem_req rises (or never).
  task automatic run_access(input logic drv_if, input logic drv_ls, input logic hold,
                            input logic exp_ls, input logic we_v,
                            input logic [31:0] if_a, input logic [31:0] ls_a,
                            input logic [31:0] wd, input logic [3:0] be,
                            input int k, input logic do_ack, input logic [31:0] rd);
    exp_t        x;
    logic [31:0] ea;
    logic [3:0]  eb;
    @(negedge clk);
    if_req = drv_if; if_addr = if_a;
    ls_req = drv_ls; ls_we = we_v; ls_addr = ls_a; ls_wdata = wd; ls_be = be;
    #1;
    check1("if_gnt", if_gnt, ~exp_ls);
    check1("ls_gnt", ls_gnt, exp_ls);
    x.is_ls = exp_ls;
    x.data  = do_ack ? rd : 32'h0;
    x.err   = ~do_ack;
    x.cyc   = cyc + 2 + k;
    sb_q.push_back(x);
    ea = exp_ls ? ls_a : if_a;
    eb = exp_ls ? be : 4'hF;
    for (int i = 0; i <= k; i++) begin
      @(negedge clk);
      if (i == 0 && !hold) begin
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_be = 4'h0;
      end
      #1;
      check1("mem_req_busy", mem_req, 1'b1);
      check32("mem_addr", mem_addr, ea);
      check32("mem_be", {28'h0, mem_be}, {28'h0, eb});
      check1("mem_we", mem_we, exp_ls & we_v);
      check1("sel", sel, exp_ls);
      check1("gnt_in_busy", if_gnt | ls_gnt, 1'b0);
      if (exp_ls) check32("mem_wdata", mem_wdata, wd);
      if (i == k && do_ack) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    check1("mem_req_done", mem_req, 1'b0);
  endtask

  initial begin
    logic [5:0] order6;
    logic [4:0] order5;
    order6 = 6'b101111;
    order5 = 5'b01111;
    rst = 1'b1;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_ack = 1'b0;
    if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0; mem_rdata = 32'h0; ls_be = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_sel", sel, 1'b0);
    check1("rst_rvalid", if_rvalid | ls_rvalid, 1'b0);
    check1("rst_err", err, 1'b0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check1("rst_gnt", if_gnt | ls_gnt, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // IF read, ack two cycles after mem_req
    run_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 2, 1'b1, 32'h1234_5678);

    // Contention with both requests held: LS x4, IF, LS
    for (int i = 0; i < 6; i++)
      run_access(1'b1, 1'b1, 1'b1, order6[i], 1'b0, 32'h300, 32'h400 + 32'(i), 32'h0, 4'hC,
                 0, 1'b1, 32'hA000_0000 + 32'(i));
    if_req = 1'b0; ls_req = 1'b0;

    // LS write with partial byte enables
    run_access(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h2000, 32'hDEAD_BEEF, 4'h3, 3, 1'b1, 32'h0);
    // LS read, immediate ack
    run_access(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h600, 32'h0, 4'hF, 0, 1'b1, 32'hCAFE_F00D);
    // IF read that never gets an ack: 64 BUSY cycles then err
    run_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0, 4'h0, 63, 1'b0, 32'hFFFF_FFFF);

    // Contested LS grant (streak 1), then reset while BUSY
    @(negedge clk);
    if_req = 1'b1; ls_req = 1'b1; ls_addr = 32'h700; if_addr = 32'h710;
    #1;
    check1("abort_ls_gnt", ls_gnt, 1'b1);
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b0;
    #1;
    check1("abort_busy", mem_req, 1'b1);
    check1("abort_sel", sel, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check1("abort_mem_req", mem_req, 1'b0);
    check1("abort_sel_rst", sel, 1'b0);
    check1("abort_no_rvalid", if_rvalid | ls_rvalid, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // Streak must restart from zero: four LS wins before IF
    for (int i = 0; i < 5; i++)
      run_access(1'b1, 1'b1, 1'b1, order5[i], 1'b0, 32'h800, 32'h900, 32'h0, 4'h1,
                 1, 1'b1, 32'hB000_0000 + 32'(i));
    if_req = 1'b0; ls_req = 1'b0;

    // Stray ack in IDLE
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    repeat (2) @(negedge clk);
    #1;
    check1("stray_mem_req", mem_req, 1'b0);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    run_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC00, 32'h0, 32'h0, 4'h0, 1, 1'b1, 32'h5555_AAAA);

    repeat (4) @(negedge clk);
    check32("scoreboard_drained", sb_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
